// File: rtl/spm_1p_rsp_adapter_if.sv
// Request, response and memory-side signals of the single-port SPM response adapter.
// Signal directions are named from the adapter's point of view.
interface spm_1p_rsp_adapter_if #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeWidth   = 16
) ();
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_wdata_i;
  logic [BeWidth-1:0]   req_be_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic [BeWidth-1:0]   mem_be_o;
  logic [DataWidth-1:0] mem_rdata_i;
  logic                 busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, busy_o
  );
endinterface

// File: rtl/spm_1p_rsp_adapter.sv
// Valid/ready front-end for a 1-cycle-latency single-port SPM. Reads are admitted only
// when a response FIFO slot is guaranteed, so the response consumer may stall freely.
module spm_1p_rsp_adapter #(
  parameter int unsigned  NumWords  = 1024,
  parameter int unsigned  DataWidth = 128,
  parameter int unsigned  ByteWidth = 8,
  parameter int unsigned  RspDepth  = 3,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input logic                 clk_i,
  input logic                 rst_i,
  spm_1p_rsp_adapter_if.slave bus
);
  localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntWidth = $clog2(RspDepth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(RspDepth - 1);
  localparam logic [CntWidth:0]   Credits = (CntWidth + 1)'(RspDepth);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(RspDepth);

  logic                 inflight_q, inflight_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DataWidth-1:0] storage_q [RspDepth];

  logic ready, accept, push, pop, rsp_valid;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A credit is held from read accept until the response is popped.
  assign ready     = !rst_i && (({1'b0, count_q} + {{CntWidth{1'b0}}, inflight_q}) < Credits);
  assign accept    = bus.req_valid_i && ready;
  assign push      = inflight_q;
  assign rsp_valid = !rst_i && (count_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready_i;

  assign bus.req_ready_o = ready;
  assign bus.mem_req_o   = accept;
  assign bus.mem_we_o    = bus.req_we_i;
  assign bus.mem_addr_o  = bus.req_addr_i;
  assign bus.mem_wdata_o = bus.req_wdata_i;
  assign bus.mem_be_o    = bus.req_be_i;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rst_i ? '0 : storage_q[rd_ptr_q];
  assign bus.busy_o      = !rst_i && (inflight_q || (count_q != '0));

  always_comb begin
    inflight_d = accept && !bus.req_we_i;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < RspDepth; i++) storage_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) storage_q[wr_ptr_q] <= bus.mem_rdata_i;
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (count_q == FullCnt)));

endmodule

// File: tb/tb_spm_1p_rsp_adapter.sv
// Scoreboard bench: a monitor compares every cycle against an outstanding-request
// queue and a shadow memory; a behavioural SPM with 1-cycle read latency sits behind the DUT.
module tb_spm_1p_rsp_adapter;
  localparam int AW = 10;
  localparam int DW = 128;
  localparam int BW = 16;
  localparam int DEPTH = 3;
  localparam int TIMEOUT = 200;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   acc_cnt = 0;
  bit   rand_rdy = 0;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  rsp_t sb[$];

  spm_1p_rsp_adapter_if #(.AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus ();

  spm_1p_rsp_adapter #(.NumWords(1024), .DataWidth(DW), .ByteWidth(8), .RspDepth(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SPM; read data is garbage except the cycle after a read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req_o && bus.mem_we_o) begin
      for (int b = 0; b < BW; b++)
        if (bus.mem_be_o[b]) mem[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
    end
    if (bus.mem_req_o && !bus.mem_we_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    else bus.mem_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outstanding reads are exactly the queue entries; a response becomes
  // visible two cycles after its accept and leaves on a handshake.
  always @(negedge clk) begin
    logic exp_ready, exp_valid, accept;
    logic [DW-1:0] d;
    exp_ready = !rst && (sb.size() < DEPTH);
    accept    = bus.req_valid_i && exp_ready;
    check("req_ready", DW'(bus.req_ready_o), DW'(exp_ready));
    check("mem_req", DW'(bus.mem_req_o), DW'(accept));
    if (accept) begin
      check("mem_we", DW'(bus.mem_we_o), DW'(bus.req_we_i));
      check("mem_addr", DW'(bus.mem_addr_o), DW'(bus.req_addr_i));
      check("mem_be", DW'(bus.mem_be_o), DW'(bus.req_be_i));
      if (bus.req_we_i) check("mem_wdata", bus.mem_wdata_o, bus.req_wdata_i);
    end
    if (rst) begin
      check("rst_rsp_valid", DW'(bus.rsp_valid_o), '0);
      check("rst_busy", DW'(bus.busy_o), '0);
      check("rst_rdata", bus.rsp_rdata_o, '0);
      sb.delete();
    end else begin
      exp_valid = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
      check("rsp_valid", DW'(bus.rsp_valid_o), DW'(exp_valid));
      check("busy", DW'(bus.busy_o), DW'(sb.size() > 0));
      if (exp_valid) begin
        check("rsp_rdata", bus.rsp_rdata_o, sb[0].data);
        if (bus.rsp_ready_i) void'(sb.pop_front());
      end
      if (accept) begin
        acc_cnt++;
        if (bus.req_we_i) begin
          for (int b = 0; b < BW; b++)
            if (bus.req_be_i[b]) ref_mem[bus.req_addr_i][b*8 +: 8] = bus.req_wdata_i[b*8 +: 8];
        end else begin
          d = ref_mem[bus.req_addr_i];
          sb.push_back('{data: d, cyc: cyc});
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be);
    int n = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.req_be_i    = be;
    if (rand_rdy) bus.rsp_ready_i = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (bus.req_ready_o) break;
      n++;
      if (n > TIMEOUT) begin
        vectors++;
        miscompares++;
        $display("FAIL issue_timeout cyc=%0d got=no_accept want=accept", cyc);
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) bus.rsp_ready_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    rand_rdy = 0;
    bus.rsp_ready_i = 1'b1;
    while (sb.size() > 0 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout got=%0d_pending want=0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int acc0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = rnd_data();
      ref_mem[i] = mem[i];
    end
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 10'd3;
    bus.req_wdata_i = '0;
    bus.req_be_i    = '1;
    bus.rsp_ready_i = 1'b1;

    // Reset held with a request pending
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(posedge clk); #1;

    // Write then read back
    issue(1'b1, 10'd5, {16{8'hA5}}, '1);
    issue(1'b0, 10'd5, '0, '0);
    drain();

    // Streaming reads
    for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), rnd_data(), BW'($urandom));
    drain();

    // Backpressure: only DEPTH reads admitted
    bus.rsp_ready_i = 1'b0;
    acc0 = acc_cnt;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr_i = AW'($urandom_range(0, 1023));
      @(posedge clk); #1;
    end
    idle();
    check("bp_accepts", DW'(acc_cnt - acc0), DW'(DEPTH));
    drain();

    // Pointer wrap with random consumer stalls, partial byte enables
    rand_rdy = 1;
    for (int i = 0; i < 10; i++) issue(1'b0, AW'($urandom_range(0, 15)), '0, '0);
    for (int i = 0; i < 4; i++) issue(1'b1, AW'($urandom_range(0, 15)), rnd_data(), BW'($urandom));
    for (int i = 0; i < 10; i++) issue(1'b0, AW'($urandom_range(0, 15)), '0, '0);
    drain();

    // Reset with two entries buffered and one read in flight
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(20 + i), '0, '0);
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 10'd21, '0, '0);
    drain();

    // Random mixed traffic on a small address window
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), rnd_data(), BW'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
